// File: rtl/uart_rxd_pkg.sv
// Shared definitions for the UART receiver: default timing constants and the
// receive state encoding (same 2-bit encoding the transmitter uses).
package uart_rxd_pkg;

   // 100 MHz system clock, 9600 baud
   localparam int unsigned CLKS_PER_BIT_DEF = 10416;
   // Bit-timer width; 2**14 comfortably exceeds the default bit period
   localparam int unsigned CNT_W_DEF        = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rxd_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus a registered copy
// of the synchronized value so a clean falling edge can be detected.
module uart_rxd_sync (
   input  logic clk,
   input  logic rst_n,    // synchronous, active-high
   input  logic rx,
   output logic rx_sync,
   output logic fall
);

   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;

   // Synchronizer chain and edge register; all flops reset to the idle level
   always_ff @(posedge clk) begin
      // NOTE: rst_n is active-HIGH and synchronous here to match the
      // transmitter's port; loading 1 keeps reset from looking like a start edge.
      if (rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make each flop take the previous
         // stage's old value, which is what builds a real shift chain.
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_sync = rx_sync_q;
   assign fall    = rx_prev_q & ~rx_sync_q;

endmodule

// File: rtl/uart_rxd.sv
// 8N1 UART receiver. Detects a start edge, confirms it at mid-bit, samples
// eight data bits LSB first at bit centres, then checks the stop bit. A good
// frame updates data_out with a one-cycle data_valid strobe; a low stop bit
// gives a one-cycle frame_err strobe and leaves data_out untouched.
module uart_rxd
   import uart_rxd_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,  // must be >= 4
   parameter int unsigned CNT_W        = CNT_W_DEF          // 2**CNT_W > CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,       // synchronous, active-high
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_sync;
   logic fall;

   rx_state_e        state_q,   state_d;
   logic [CNT_W-1:0] timer_q,   timer_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q,   shreg_d;
   logic [7:0]       data_q,    data_d;
   logic             valid_q,   valid_d;
   logic             ferr_q,    ferr_d;
   logic             busy_q,    busy_d;

   uart_rxd_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .rx_sync (rx_sync),
      .fall    (fall)
   );

   // Next-state logic: frame sequencing, bit timing and output strobes
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Only a high-to-low transition arms; a line stuck low never does
            if (fall) begin
               state_d = START;
               timer_d = '0;
            end
         end

         START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               if (!rx_sync) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;     // glitch shorter than half a bit
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d   = '0;
               shreg_d   = {rx_sync, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end

         STOP: begin
            // Leaving at mid-stop leaves half a bit to catch a following start edge
            if (timer_q == BIT_LAST) begin
               timer_d = '0;
               state_d = IDLE;
               if (rx_sync) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered-output update
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_idx_q <= 3'd0;
         // NOTE: the shift register is reset too, so a frame abandoned by
         // reset leaves no partial byte behind.
         shreg_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rxd.sv
// Directed bench for uart_rxd with a 16-clock bit period.
module tb_uart_rxd;

   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   uart_rxd #(.CLKS_PER_BIT(CPB), .CNT_W(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Posedge counter: at a negedge, cyc is the index of the preceding posedge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled on the falling edge
   int         valid_total   = 0;
   int         ferr_total    = 0;
   int         overlap_total = 0;
   logic [7:0] vdata [0:63];
   int         vcyc  [0:63];
   int         busy_rise_cyc = 0;
   int         busy_fall_cyc = 0;
   logic       busy_prev     = 1'b0;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         if (valid_total < 64) begin
            vdata[valid_total] <= data_out;
            vcyc[valid_total]  <= cyc;
         end
         valid_total <= valid_total + 1;
      end
      if (frame_err === 1'b1) ferr_total <= ferr_total + 1;
      if (data_valid === 1'b1 && frame_err === 1'b1) overlap_total <= overlap_total + 1;
      if (busy === 1'b1 && !busy_prev) busy_rise_cyc <= cyc;
      if (busy === 1'b0 && busy_prev)  busy_fall_cyc <= cyc;
      busy_prev <= (busy === 1'b1);
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Called at a negedge; t0 is the first posedge that samples the start bit
   task automatic send_frame(input logic [7:0] d, input logic stop_b, output int t0);
      t0 = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_b);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else pass_cnt++;
      total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else pass_cnt++;
      total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      rst_n = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int v0, f0, t0;
      v0 = valid_total; f0 = ferr_total;
      send_frame(8'hA5, 1'b1, t0);
      repeat (20) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 1) $display("FAIL a5_valid_count: got %0d want 1", valid_total - v0); else pass_cnt++;
      total_cnt++; if (vdata[v0] !== 8'hA5) $display("FAIL a5_data: got %h want a5", vdata[v0]); else pass_cnt++;
      total_cnt++; if (ferr_total - f0 !== 0) $display("FAIL a5_frame_err: got %0d want 0", ferr_total - f0); else pass_cnt++;
      total_cnt++; if (busy_rise_cyc - t0 !== 2) $display("FAIL a5_busy_rise: got %0d want 2", busy_rise_cyc - t0); else pass_cnt++;
      total_cnt++; if (busy_fall_cyc - t0 !== 154) $display("FAIL a5_busy_fall: got %0d want 154", busy_fall_cyc - t0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int v0, f0, t0a, t0b;
      v0 = valid_total; f0 = ferr_total;
      send_frame(8'h00, 1'b1, t0a);
      send_frame(8'hFF, 1'b1, t0b);
      repeat (20) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 2) $display("FAIL b2b_valid_count: got %0d want 2", valid_total - v0); else pass_cnt++;
      total_cnt++; if (vdata[v0] !== 8'h00) $display("FAIL b2b_first_data: got %h want 00", vdata[v0]); else pass_cnt++;
      total_cnt++; if (vdata[v0+1] !== 8'hFF) $display("FAIL b2b_second_data: got %h want ff", vdata[v0+1]); else pass_cnt++;
      total_cnt++; if (vcyc[v0+1] - vcyc[v0] !== 160) $display("FAIL b2b_spacing: got %0d want 160", vcyc[v0+1] - vcyc[v0]); else pass_cnt++;
      total_cnt++; if (ferr_total - f0 !== 0) $display("FAIL b2b_frame_err: got %0d want 0", ferr_total - f0); else pass_cnt++;
   endtask

   task automatic test_glitch();
      int v0, f0, t0;
      v0 = valid_total; f0 = ferr_total;
      t0 = cyc + 1;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 0) $display("FAIL glitch_valid: got %0d want 0", valid_total - v0); else pass_cnt++;
      total_cnt++; if (ferr_total - f0 !== 0) $display("FAIL glitch_frame_err: got %0d want 0", ferr_total - f0); else pass_cnt++;
      total_cnt++; if (busy_rise_cyc - t0 !== 2) $display("FAIL glitch_busy_rise: got %0d want 2", busy_rise_cyc - t0); else pass_cnt++;
      total_cnt++; if (busy_fall_cyc - t0 !== 10) $display("FAIL glitch_busy_fall: got %0d want 10", busy_fall_cyc - t0); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_idle: got busy=%b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_frame_error_break();
      int   v0, f0, t0;
      logic busy_seen;
      v0 = valid_total; f0 = ferr_total;
      send_frame(8'h3C, 1'b0, t0);
      busy_seen = 1'b0;
      repeat (100) @(negedge clk) if (busy !== 1'b0) busy_seen = 1'b1;
      total_cnt++; if (ferr_total - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_total - f0); else pass_cnt++;
      total_cnt++; if (valid_total - v0 !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_total - v0); else pass_cnt++;
      total_cnt++; if (data_out !== 8'hFF) $display("FAIL ferr_data_kept: got %h want ff", data_out); else pass_cnt++;
      total_cnt++; if (busy_seen !== 1'b0) $display("FAIL break_no_rearm: got busy_seen=%b want 0", busy_seen); else pass_cnt++;
      send_bit(1'b1);
      send_frame(8'h81, 1'b1, t0);
      repeat (20) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 1) $display("FAIL after_break_valid: got %0d want 1", valid_total - v0); else pass_cnt++;
      total_cnt++; if (data_out !== 8'h81) $display("FAIL after_break_data: got %h want 81", data_out); else pass_cnt++;
      total_cnt++; if (ferr_total - f0 !== 1) $display("FAIL after_break_ferr: got %0d want 1", ferr_total - f0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      int         v0, f0, t0;
      logic [7:0] d;
      d = 8'h5A;
      v0 = valid_total; f0 = ferr_total;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx = d[4];
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++; if (data_out !== 8'h00) $display("FAIL midrst_data_out[%0d]: got %h want 00", i, data_out); else pass_cnt++;
         total_cnt++; if (data_valid !== 1'b0) $display("FAIL midrst_valid[%0d]: got %b want 0", i, data_valid); else pass_cnt++;
         total_cnt++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr[%0d]: got %b want 0", i, frame_err); else pass_cnt++;
         total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy[%0d]: got %b want 0", i, busy); else pass_cnt++;
      end
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (200) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 0) $display("FAIL midrst_no_strobe: got %0d want 0", valid_total - v0); else pass_cnt++;
      total_cnt++; if (ferr_total - f0 !== 0) $display("FAIL midrst_no_ferr: got %0d want 0", ferr_total - f0); else pass_cnt++;
      send_frame(8'hC3, 1'b1, t0);
      repeat (20) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 1) $display("FAIL c3_valid_count: got %0d want 1", valid_total - v0); else pass_cnt++;
      total_cnt++; if (data_out !== 8'hC3) $display("FAIL c3_data: got %h want c3", data_out); else pass_cnt++;
   endtask

   task automatic test_timing();
      int v0, t0;
      v0 = valid_total;
      send_frame(8'h01, 1'b1, t0);
      repeat (20) @(negedge clk);
      total_cnt++; if (valid_total - v0 !== 1) $display("FAIL timing_valid_count: got %0d want 1", valid_total - v0); else pass_cnt++;
      total_cnt++; if (vcyc[v0] - t0 !== 154) $display("FAIL timing_latency: got %0d want 154", vcyc[v0] - t0); else pass_cnt++;
      total_cnt++; if (vdata[v0] !== 8'h01) $display("FAIL timing_data: got %h want 01", vdata[v0]); else pass_cnt++;
      total_cnt++; if (overlap_total !== 0) $display("FAIL strobe_overlap: got %0d want 0", overlap_total); else pass_cnt++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_frame_error_break();
      test_reset_mid_frame();
      test_timing();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
